// File: rtl/layer0_input_packer.sv
// Quantizes raw features against per-slot thresholds into small codes and packs
// FANIN codes per output word, with a one-deep output register and backpressure.
module layer0_input_packer #(
    parameter int FEAT_W = 8,
    parameter int FANIN  = 3,
    parameter int BW     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [FEAT_W-1:0]     s_data,
    input  logic                  s_last,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_addr,
    input  logic [FEAT_W-1:0]     cfg_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FANIN*BW-1:0]   m_data
);

    localparam int SLOT_W = (FANIN > 1) ? $clog2(FANIN) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FANIN - 1);

    logic [FEAT_W-1:0]   thr_reg [FANIN][3];
    logic [SLOT_W-1:0]   slot_reg, slot_next;
    logic [FANIN*BW-1:0] asm_reg, asm_next;
    logic [FANIN*BW-1:0] m_data_reg, m_data_next;
    logic                m_valid_reg, m_valid_next;
    logic [FANIN*BW-1:0] packed_word;
    logic [BW-1:0]       code;
    logic                ends_group;
    logic                accept;
    logic                complete;

    // Default thresholds split the input range into quarters: 1/4, 2/4, 3/4.
    function automatic logic [FEAT_W-1:0] default_thr(input int k);
        return FEAT_W'(k + 1) << (FEAT_W - 2);
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 0; i < FANIN; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    thr_reg[i][k] <= default_thr(k);
                end else if (cfg_we && cfg_addr == 4'(i * 3 + k)) begin
                    thr_reg[i][k] <= cfg_data;
                end
            end
        end
    end

    // Thermometer count of satisfied thresholds for the current slot.
    always_comb begin
        code = '0;
        for (int i = 0; i < FANIN; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (slot_reg == SLOT_W'(i) && s_data >= thr_reg[i][k]) begin
                    code = code + BW'(1);
                end
            end
        end
    end

    assign ends_group = (slot_reg == LAST_SLOT) || s_last;
    // Only a word-completing feature has to wait for the output register.
    assign s_ready    = !rst && !(m_valid_reg && !m_ready && ends_group);
    assign accept     = s_valid && s_ready;
    assign complete   = accept && ends_group;

    generate
        for (genvar gi = 0; gi < FANIN; gi++) begin : g_pack
            assign packed_word[gi*BW +: BW] =
                (slot_reg == SLOT_W'(gi)) ? code : asm_reg[gi*BW +: BW];
        end
    endgenerate

    always_comb begin
        slot_next    = slot_reg;
        asm_next     = asm_reg;
        m_valid_next = m_valid_reg;
        m_data_next  = m_data_reg;
        if (m_valid_reg && m_ready) begin
            m_valid_next = 1'b0;
        end
        if (accept) begin
            if (complete) begin
                slot_next    = '0;
                asm_next     = '0;
                m_valid_next = 1'b1;
                m_data_next  = packed_word;
            end else begin
                slot_next = slot_reg + SLOT_W'(1);
                asm_next  = packed_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg    <= '0;
            asm_reg     <= '0;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
        end else begin
            slot_reg    <= slot_next;
            asm_reg     <= asm_next;
            m_valid_reg <= m_valid_next;
            m_data_reg  <= m_data_next;
        end
    end

    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;

endmodule

// File: tb/tb_layer0_input_packer.sv
// Bench for layer0_input_packer: a behavioural threshold model feeds a queue of
// expected words that a monitor pops on every output handshake.
module tb_layer0_input_packer;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       cfg_we;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       m_valid;
    logic       m_ready;
    logic [5:0] m_data;

    layer0_input_packer #(.FEAT_W(8), .FANIN(3), .BW(2)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] exp_q[$];
    logic [5:0] sb_exp;
    logic [7:0] mthr [3][3];
    int         mslot;
    logic [5:0] masm;

    task automatic model_reset();
        mslot = 0;
        masm  = '0;
        for (int i = 0; i < 3; i++) begin
            mthr[i][0] = 8'h40;
            mthr[i][1] = 8'h80;
            mthr[i][2] = 8'hC0;
        end
    endtask

    task automatic model_accept(input logic [7:0] d, input logic last);
        logic [1:0] c;
        c = 2'd0;
        for (int k = 0; k < 3; k++) if (d >= mthr[mslot][k]) c = c + 2'd1;
        masm[mslot*2 +: 2] = c;
        if (mslot == 2 || last) begin
            exp_q.push_back(masm);
            masm  = '0;
            mslot = 0;
        end else begin
            mslot = mslot + 1;
        end
    endtask

    task automatic model_cfg(input logic [3:0] a, input logic [7:0] d);
        if (a < 4'd9) mthr[a / 3][a % 3] = d;
    endtask

    // Every output handshake pops one expected word.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: m_data=%b, required no word", m_data);
            end else begin
                sb_exp = exp_q.pop_front();
                if (m_data !== sb_exp) begin
                    n_bad++;
                    $display("FAIL sb_word: m_data=%b, required %b", m_data, sb_exp);
                end else begin
                    $display("word %b", m_data);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic last);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        #1;
        while (!s_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!s_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: s_ready=%b, required 1 within 50 cycles", s_ready);
        end else begin
            model_accept(d, last);
            if (cfg_we) model_cfg(cfg_addr, cfg_data);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        cfg_we  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; s_last = 1'b1; s_data = 8'hFF;
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 8'h00; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid: got %b, required 0", m_valid); end
        n_cmp++;
        if (m_data !== 6'b0) begin n_bad++; $display("FAIL rst_m_data: got %b, required 000000", m_data); end
        n_cmp++;
        if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready: got %b, required 0", s_ready); end
        s_valid = 1'b0; s_last = 1'b0; cfg_we = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_default();
        m_ready = 1'b1;
        send(8'h3F, 1'b0); send(8'h80, 1'b0); send(8'hFF, 1'b0);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 6'b111000) begin
            n_bad++;
            $display("FAIL default_word: valid=%b data=%b, required 1/111000", m_valid, m_data);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL default_one_cycle: m_valid=%b, required 0", m_valid); end
    endtask

    task automatic test_edges();
        send(8'h40, 1'b0); send(8'hBF, 1'b0); send(8'hC0, 1'b0);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 6'b111001) begin
            n_bad++;
            $display("FAIL edges_word: valid=%b data=%b, required 1/111001", m_valid, m_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b0;
        send(8'h10, 1'b0); send(8'h50, 1'b0); send(8'h90, 1'b0);
        send(8'h41, 1'b0); send(8'h81, 1'b0);
        s_valid = 1'b1; s_data = 8'hC1; s_last = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (s_ready !== 1'b0) begin n_bad++; $display("FAIL bp_s_ready: got %b, required 0", s_ready); end
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== 6'b100100) begin
                n_bad++;
                $display("FAIL bp_hold: valid=%b data=%b, required 1/100100", m_valid, m_data);
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        #1;
        n_cmp++;
        if (s_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release: s_ready=%b, required 1", s_ready); end
        model_accept(8'hC1, 1'b0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 6'b111001) begin
            n_bad++;
            $display("FAIL bp_second: valid=%b data=%b, required 1/111001", m_valid, m_data);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: m_valid=%b, required 0", m_valid); end
    endtask

    task automatic test_throughput();
        for (int i = 0; i < 9; i++) send(8'($urandom_range(0, 255)), 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_partial();
        send(8'hFF, 1'b1);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 6'b000011) begin
            n_bad++;
            $display("FAIL partial_word: valid=%b data=%b, required 1/000011", m_valid, m_data);
        end
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'hFF, 1'b0);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 6'b110000) begin
            n_bad++;
            $display("FAIL partial_next: valid=%b data=%b, required 1/110000", m_valid, m_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_config();
        send(8'h00, 1'b0);
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 8'h10;
        send(8'h20, 1'b0);
        send(8'h00, 1'b0);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 6'b000000) begin
            n_bad++;
            $display("FAIL cfg_old_thr: valid=%b data=%b, required 1/000000", m_valid, m_data);
        end
        cfg_we = 1'b1; cfg_addr = 4'd15; cfg_data = 8'h00;
        send(8'h00, 1'b0);
        send(8'h20, 1'b0);
        send(8'h00, 1'b0);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 6'b000100) begin
            n_bad++;
            $display("FAIL cfg_new_thr: valid=%b data=%b, required 1/000100", m_valid, m_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        send(8'h41, 1'b0); send(8'h81, 1'b0);
        n_cmp++;
        if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_word: m_valid=%b, required 0", m_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst: m_valid=%b s_ready=%b, required 0/0", m_valid, s_ready);
        end
        rst = 1'b0;
        model_reset();
        send(8'h3F, 1'b0); send(8'h20, 1'b0); send(8'hFF, 1'b0);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 6'b110000) begin
            n_bad++;
            $display("FAIL mid_fresh: valid=%b data=%b, required 1/110000", m_valid, m_data);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; m_ready = 1'b0;
        model_reset();
        test_reset();
        test_default();
        test_edges();
        test_back_to_back();
        test_throughput();
        test_partial();
        test_config();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d words outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/layer0_input_packer.md
LAYER0_INPUT_PACKER -- requirements
Module: layer0_input_packer

Interface
REQ-001 The block SHALL have parameter FEAT_W, default 8, meaning raw feature width in bits.
REQ-002 The block SHALL have parameter FANIN, default 3, meaning features packed per output word.
REQ-003 The block SHALL have parameter BW, default 2, meaning quantized code width per feature.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port s_valid, input, 1, raw feature valid.
REQ-007 The block SHALL have port s_ready, output, 1, raw feature accepted when s_valid && s_ready.
REQ-008 The block SHALL have port s_data, input, FEAT_W, unsigned raw feature value.
REQ-009 The block SHALL have port s_last, input, 1, marks the final feature of a group; it forces emission of a partial word.
REQ-010 The block SHALL have port cfg_we, input, 1, threshold write strobe.
REQ-011 The block SHALL have port cfg_addr, input, 4, threshold index = slot*3 + k, with k in 0..2.
REQ-012 The block SHALL have port cfg_data, input, FEAT_W, threshold value.
REQ-013 The block SHALL have port m_valid, output, 1, packed word valid.
REQ-014 The block SHALL have port m_ready, input, 1, downstream neuron-layer accept.
REQ-015 The block SHALL have port m_data, output, FANIN*BW, packed word; slot i occupies bits [BW*i+BW-1 : BW*i].

Function
REQ-016 Each accepted feature SHALL be quantized to code = number of slot thresholds k (0..2) with s_data >= T[slot][k], range 0..3.
- Equality counts as satisfied.
- Thresholds need not be monotonic.
REQ-017 A slot counter SHALL start at 0 and advance by 1 on each accept.
- After the accept in slot FANIN-1, or any accept with s_last=1, the code is packed and the counter returns to 0.
REQ-018 Codes of slots not yet filled when s_last ends a group SHALL be 2'b00 in the emitted word.
REQ-019 Codes SHALL be held in an internal assembly register.
- The completed word SHALL appear on m_data with m_valid=1 exactly one cycle after the completing accept (latency 1).
REQ-020 m_valid/m_data SHALL remain stable until m_valid && m_ready.
REQ-021 The output register SHALL clear m_valid on the handshake cycle unless a new word completes in that same cycle.
- If a new word completes in that cycle, the new word SHALL be loaded with m_valid kept at 1 (back-to-back, no bubble).
REQ-022 s_ready SHALL be 0 only when a completing accept would occur while m_valid=1 and m_ready=0.
- Concretely: s_ready = !(m_valid && !m_ready && (slot==FANIN-1 || s_last)).
- Non-completing features SHALL be accepted regardless of output state.
- s_ready SHALL depend combinationally on m_ready and s_last.
REQ-023 A cfg_we write SHALL update T[cfg_addr/3][cfg_addr%3] at the clock edge.
- A feature accepted in the same cycle SHALL use the old threshold.
- cfg_addr >= FANIN*3 SHALL be ignored.
REQ-024 Sustained throughput SHALL be one feature per cycle with m_ready held at 1.
REQ-025 Data integrity SHALL hold with no loss or duplication of features under arbitrary s_valid/m_ready patterns.

Reset
REQ-026 On rst=1 the following SHALL clear at the clock edge:
- m_valid=0, m_data=0, slot counter=0, assembly register=0.
- A partial group in progress is discarded.
REQ-027 On rst=1 every slot's thresholds SHALL reset to T[k] = {2^(FEAT_W-2), 2^(FEAT_W-1), 3*2^(FEAT_W-2)}, i.e. 0x40/0x80/0xC0 for FEAT_W=8.
REQ-028 During rst=1, s_ready SHALL be 0 and cfg_we SHALL be ignored.

Verification
REQ-029 The bench SHALL check default thresholds: after reset, features 0x3F, 0x80, 0xFF with m_ready=1 -> one cycle after the third accept m_data=6'b111000 (slot0=0, slot1=2, slot2=3), m_valid=1 for one cycle.
REQ-030 The bench SHALL check threshold edges: features 0x40, 0xBF, 0xC0 -> m_data=6'b111001.
REQ-031 The bench SHALL check backpressure: m_ready=0 with two full groups offered -> first word held stable, s_ready=0 on the sixth feature until m_ready=1; second word emitted next cycle, no loss.
REQ-032 The bench SHALL check partial group: single feature 0xFF with s_last=1 -> m_data=6'b000011; the next group starts at slot0.
REQ-033 The bench SHALL check config timing: write T[1][0]=0x10 in the same cycle that slot1 feature 0x20 is accepted -> code uses old 0x40 (code 0); the next group's slot1 0x20 -> code 1.
REQ-034 The bench SHALL check reset mid-group: rst after two accepts -> m_valid=0, thresholds default; the next three features form a fresh word.
